prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader that drives the CPU instruction-memory write port (w_instruction/w_enable/w_adrs).
//  Consumes a framed byte stream (length, big-endian 32-bit words, XOR checksum) over a valid/ready handshake.
//  Writes each word to sequential addresses while holding cpu_en low, then releases the CPU on a good frame.
//  Sits between the host byte link (e.g. UART RX) and top_level; replaces bench-driven memory preload.
// PARAMETERS
//  ADDR_W      11  width of w_adrs
//  DATA_W      32  instruction word width; fixed at 4 bytes
//  START_ADRS  1   first memory address written by each frame
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  reset          in   1       asynchronous, active-high reset
//  start          in   1       1-cycle pulse: begin new frame (honoured in IDLE/DONE/ERROR only)
//  in_data        in   8       stream byte
//  in_valid       in   1       in_data valid
//  in_ready       out  1       loader accepts byte; transfer = in_valid & in_ready
//  w_instruction  out  DATA_W  word to memory
//  w_enable       out  1       memory write strobe, 1 cycle per word
//  w_adrs         out  ADDR_W  memory write address
//  cpu_en         out  1       CPU run enable
//  busy           out  1       frame in progress
//  done           out  1       frame loaded, checksum good
//  error          out  1       checksum mismatch or address overflow
//  words_written  out  16      words written in current/last frame
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0, w_enable=0, w_instruction=0, w_adrs=START_ADRS, cpu_en=0,
//   busy=0, done=0, error=0, words_written=0, checksum=0, length=0.
//  Frame: LEN_HI, LEN_LO (16-bit word count N), N x 4 data bytes MSB first, 1 checksum byte.
//   Checksum = XOR of every byte preceding it (length bytes + data bytes).
//  FSM: IDLE -start-> LEN_HI -byte-> LEN_LO -byte-> (N==0 ? CHECK : DATA);
//   DATA -4th byte of word N-> CHECK; CHECK -byte-> (match ? DONE : ERROR);
//   DONE/ERROR -start-> LEN_HI. start ignored in LEN_HI/LEN_LO/DATA/CHECK.
//  On start: cpu_en=0, done=0, error=0, words_written=0, checksum=0, w_adrs=START_ADRS, busy=1.
//  in_ready=1 in LEN_HI, LEN_LO, DATA, CHECK; 0 in IDLE, DONE, ERROR. No internal backpressure.
//  Word assembly: shift register, byte count 0..3. Cycle after accepting byte 3:
//   w_enable=1 for exactly 1 cycle, w_instruction=assembled word, w_adrs=current address;
//   next cycle w_adrs+1, words_written+1. A byte may be accepted in the strobe cycle.
//  Overflow: word completes while w_adrs==2^ADDR_W-1 already written -> no write, go ERROR
//   (i.e. last writable address is 2^ADDR_W-1; address never wraps).
//  DONE: cpu_en=1, done=1, busy=0, held until next start. ERROR: cpu_en=0, error=1, busy=0.
//  Data written before a checksum failure stays in memory; loader does not clear it.
//  in_valid gaps of any length allowed in any receiving state; no timeout.
//  Reset mid-frame: immediate return to reset values; partial memory contents left as-is.
//  done and error never both 1; w_enable never 1 outside DATA/its strobe cycle.
// STRUCTURE
//  Shared package/include (loader_defs): state encodings, LEN_BYTES=2, WORD_BYTES=4.
//  One sub-module natural: loader_word_asm (byte shift, byte count, word_ready pulse).
//  FSM, address counter, checksum and handshake remain in prog_loader.
// TESTING
//  Single word, START_ADRS=1: 00 01 12 34 56 78 09 -> one w_enable, w_adrs=1, w_instruction=32'h12345678,
//   then done=1, cpu_en=1, words_written=1.
//  Same frame, checksum 08 -> write at adrs 1 still occurs; error=1, done=0, cpu_en=0.
//  Empty frame 00 00 00 -> no w_enable pulses, done=1, cpu_en=1, words_written=0.
//  START_ADRS=2046, N=3 -> writes at 2046, 2047; third word completes -> no write, error=1.
//  Two-word frame with random in_valid gaps (0-5 cycles) -> identical writes to gap-free run;
//   start pulses mid-frame ignored.
//  reset asserted after 2 of 4 data bytes -> all outputs at reset values next edge;
//   fresh start + good frame loads normally.

Source files
------------

// File: rtl/loader_defs.sv
// Shared definitions for the program loader: FSM states and frame geometry.
package loader_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: shifts bytes in, pulses word_ready the cycle after the 4th byte.
module loader_word_asm
    import loader_defs::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic [DATA_W-1:0] word,
    output logic [1:0]        byte_cnt,
    output logic              word_ready
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                word       <= {word[DATA_W-9:0], byte_in};
                byte_cnt   <= byte_cnt + 2'd1;
                word_ready <= (byte_cnt == 2'(WORD_BYTES - 1));
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader writing instruction memory, then releasing the CPU on a good checksum.
module prog_loader
    import loader_defs::*;
#(
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned START_ADRS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] w_instruction,
    output logic              w_enable,
    output logic [ADDR_W-1:0] w_adrs,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_written
);

    state_t      state, state_next;
    logic [15:0] length;
    logic [15:0] words_rx;
    logic [7:0]  checksum;
    logic        adrs_full;
    logic        transfer;
    logic        start_ok;
    logic        asm_ld;
    logic        last_byte;
    logic        last_word;
    logic        overflow;
    logic [1:0]  byte_cnt;
    logic        word_ready;

    assign transfer  = in_valid & in_ready;
    assign start_ok  = start & (state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign asm_ld    = transfer & (state == ST_DATA);
    assign last_byte = asm_ld & (byte_cnt == 2'(WORD_BYTES - 1));
    assign last_word = (words_rx == length - 16'd1);
    // adrs_full marks that the top address already holds a word; a further word has nowhere to go
    assign overflow  = word_ready & adrs_full;
    assign w_enable  = word_ready & ~adrs_full;

    assign in_ready = state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK};
    assign busy     = in_ready;
    assign done     = (state == ST_DONE);
    assign cpu_en   = (state == ST_DONE);
    assign error    = (state == ST_ERROR);

    loader_word_asm #(.DATA_W(DATA_W)) u_word_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .byte_in    (in_data),
        .byte_valid (asm_ld),
        .word       (w_instruction),
        .byte_cnt   (byte_cnt),
        .word_ready (word_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) state_next = ST_LEN_HI;
            ST_LEN_HI: if (transfer) state_next = ST_LEN_LO;
            ST_LEN_LO: if (transfer)
                state_next = ({length[15:8], in_data} == 16'd0) ? ST_CHECK : ST_DATA;
            ST_DATA:   if (last_byte && last_word) state_next = ST_CHECK;
            ST_CHECK:  if (transfer)
                state_next = (in_data == checksum) ? ST_DONE : ST_ERROR;
            default:   state_next = ST_IDLE;
        endcase
        // The final strobe may overlap the checksum byte; an overflow there still wins
        if (overflow) state_next = ST_ERROR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            length        <= '0;
            words_rx      <= '0;
            checksum      <= '0;
            w_adrs        <= ADDR_W'(START_ADRS);
            words_written <= '0;
            adrs_full     <= 1'b0;
        end else if (start_ok) begin
            length        <= '0;
            words_rx      <= '0;
            checksum      <= '0;
            w_adrs        <= ADDR_W'(START_ADRS);
            words_written <= '0;
            adrs_full     <= 1'b0;
        end else begin
            if (transfer && (state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA}))
                checksum <= checksum ^ in_data;
            if (transfer && state == ST_LEN_HI) length[15:8] <= in_data;
            if (transfer && state == ST_LEN_LO) length[7:0]  <= in_data;
            if (last_byte) words_rx <= words_rx + 16'd1;
            if (w_enable) begin
                words_written <= words_written + 16'd1;
                if (w_adrs == '1) adrs_full <= 1'b1;
                else              w_adrs    <= w_adrs + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (START_ADRS 1 and 2046) share one stimulus stream.
module tb_prog_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        in_ready,  in_ready_h;
    logic [31:0] w_instr,   w_instr_h;
    logic        w_en,      w_en_h;
    logic [10:0] w_adrs,    w_adrs_h;
    logic        cpu_en,    cpu_en_h;
    logic        busy,      busy_h;
    logic        done,      done_h;
    logic        error,     error_h;
    logic [15:0] ww,        ww_h;

    int compares = 0;
    int fails    = 0;

    logic [10:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [10:0] wah_q[$];
    logic [31:0] wdh_q[$];
    logic [7:0]  frame[$];
    int          gaps[8] = '{3, 0, 5, 1, 2, 4, 0, 5};

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(11), .DATA_W(32), .START_ADRS(1)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .w_instruction(w_instr), .w_enable(w_en), .w_adrs(w_adrs),
        .cpu_en(cpu_en), .busy(busy), .done(done), .error(error), .words_written(ww)
    );

    prog_loader #(.ADDR_W(11), .DATA_W(32), .START_ADRS(2046)) dut_h (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_h), .w_instruction(w_instr_h), .w_enable(w_en_h), .w_adrs(w_adrs_h),
        .cpu_en(cpu_en_h), .busy(busy_h), .done(done_h), .error(error_h), .words_written(ww_h)
    );

    always @(negedge clk) begin
        if (w_en)   begin wa_q.push_back(w_adrs);    wd_q.push_back(w_instr);    end
        if (w_en_h) begin wah_q.push_back(w_adrs_h); wdh_q.push_back(w_instr_h); end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        check("in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gapped);
        for (int i = 0; i < frame.size(); i++) begin
            if (gapped && (i == 3 || i == 7)) pulse_start();
            send_byte(frame[i], gapped ? gaps[i % 8] : 0);
        end
        tick();
    endtask

    task automatic clear_q();
        wa_q.delete(); wd_q.delete(); wah_q.delete(); wdh_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_w_enable", 32'(w_en), 0);
        check("rst_w_instr",  w_instr, 0);
        check("rst_w_adrs",   32'(w_adrs), 1);
        check("rst_w_adrs_h", 32'(w_adrs_h), 2046);
        check("rst_cpu_en",   32'(cpu_en), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_done",     32'(done), 0);
        check("rst_error",    32'(error), 0);
        check("rst_words",    32'(ww), 0);

        // Single good word
        clear_q();
        pulse_start();
        check("t1_busy", 32'(busy), 1);
        check("t1_ready", 32'(in_ready), 1);
        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_frame(0);
        check("t1_nwrites", wa_q.size(), 1);
        check("t1_adrs", 32'(wa_q[0]), 1);
        check("t1_data", wd_q[0], 32'h12345678);
        check("t1_done", 32'(done), 1);
        check("t1_cpu_en", 32'(cpu_en), 1);
        check("t1_error", 32'(error), 0);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_words", 32'(ww), 1);
        check("t1_ready_end", 32'(in_ready), 0);

        // Bad checksum: write still happens
        clear_q();
        pulse_start();
        check("t2_done_clr", 32'(done), 0);
        check("t2_cpu_clr", 32'(cpu_en), 0);
        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_frame(0);
        check("t2_nwrites", wa_q.size(), 1);
        check("t2_adrs", 32'(wa_q[0]), 1);
        check("t2_data", wd_q[0], 32'h12345678);
        check("t2_error", 32'(error), 1);
        check("t2_done", 32'(done), 0);
        check("t2_cpu_en", 32'(cpu_en), 0);

        // Empty frame
        clear_q();
        pulse_start();
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0);
        check("t3_nwrites", wa_q.size(), 0);
        check("t3_done", 32'(done), 1);
        check("t3_cpu_en", 32'(cpu_en), 1);
        check("t3_words", 32'(ww), 0);
        check("t3_error", 32'(error), 0);

        // N=3: low instance completes, high instance overflows on the third word
        clear_q();
        pulse_start();
        frame = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                  8'h55, 8'h66, 8'h77, 8'h88, 8'h8B};
        send_frame(0);
        check("t4_nwrites", wa_q.size(), 3);
        check("t4_adrs2", 32'(wa_q[2]), 3);
        check("t4_data2", wd_q[2], 32'h55667788);
        check("t4_done", 32'(done), 1);
        check("t4_words", 32'(ww), 3);
        check("t4h_nwrites", wah_q.size(), 2);
        check("t4h_adrs0", 32'(wah_q[0]), 2046);
        check("t4h_data0", wdh_q[0], 32'hAABBCCDD);
        check("t4h_adrs1", 32'(wah_q[1]), 2047);
        check("t4h_data1", wdh_q[1], 32'h11223344);
        check("t4h_error", 32'(error_h), 1);
        check("t4h_done", 32'(done_h), 0);
        check("t4h_cpu_en", 32'(cpu_en_h), 0);
        check("t4h_words", 32'(ww_h), 2);

        // Two words, gap-free then with gaps and ignored mid-frame starts
        for (int g = 0; g < 2; g++) begin
            clear_q();
            pulse_start();
            frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'h7B};
            send_frame(g[0]);
            check("t5_nwrites", wa_q.size(), 2);
            check("t5_adrs0", 32'(wa_q[0]), 1);
            check("t5_data0", wd_q[0], 32'hDEADBEEF);
            check("t5_adrs1", 32'(wa_q[1]), 2);
            check("t5_data1", wd_q[1], 32'h0BADF00D);
            check("t5_done", 32'(done), 1);
            check("t5_words", 32'(ww), 2);
        end

        // Reset mid-frame after two data bytes
        clear_q();
        pulse_start();
        frame = '{8'h00, 8'h01, 8'h12, 8'h34};
        for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 0);
        reset = 1'b1;
        #1;
        check("t6_ready", 32'(in_ready), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_adrs", 32'(w_adrs), 1);
        check("t6_instr", w_instr, 0);
        check("t6_done", 32'(done), 0);
        check("t6_error", 32'(error), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("t6_nwrites_rst", wa_q.size(), 0);
        pulse_start();
        frame = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h31};
        send_frame(0);
        check("t6_nwrites", wa_q.size(), 1);
        check("t6_adrs_w", 32'(wa_q[0]), 1);
        check("t6_data", wd_q[0], 32'hCAFEBABE);
        check("t6_done_end", 32'(done), 1);
        check("t6_cpu_en", 32'(cpu_en), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
